// File: rtl/mem_bus_ctrl.sv
// Bus interface unit between the load/store path and the shared 64-bit RAM bus.
// Handles one request at a time; sub-dword stores go through read-modify-write.
module mem_bus_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  inout  wire  [63:0] bus_data,
  output logic [63:0] bus_addr,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        ram_oe
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] TURN  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the response is a one-cycle rsp_valid
  // pulse with no backpressure.
  logic [2:0]  state;
  logic        we_q;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] wdata_q;
  logic [63:0] rd_buf;
  logic [3:0]  wcnt;

  logic        misaligned;
  logic [5:0]  shift;
  logic [63:0] load_shifted;
  logic [63:0] load_ext;
  logic [63:0] size_mask;
  logic [63:0] bit_mask;
  logic [63:0] wr_dword;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Little-endian lane selection: byte offset within the dword sets the shift.
  assign shift        = {addr_q[2:0], 3'b000};
  assign load_shifted = bus_data >> shift;

  always_comb begin
    load_ext  = load_shifted;
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size_q)
      2'd0: begin
        load_ext  = {{56{~uns_q & load_shifted[7]}}, load_shifted[7:0]};
        size_mask = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        load_ext  = {{48{~uns_q & load_shifted[15]}}, load_shifted[15:0]};
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        load_ext  = {{32{~uns_q & load_shifted[31]}}, load_shifted[31:0]};
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        load_ext  = load_shifted;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
  end

  // Alignment guarantees the shifted mask never spills past lane 7.
  assign bit_mask = size_mask << shift;
  assign wr_dword = (size_q == 2'd3) ? wdata_q
                  : ((rd_buf & ~bit_mask) | ((wdata_q << shift) & bit_mask));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      rd_buf    <= '0;
      wcnt      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            if (misaligned) begin
              state     <= RESP;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else if (req_we && req_size == 2'd3) begin
              state <= WRITE;
              wcnt  <= WAIT_LOAD;
            end else begin
              state <= READ;
              wcnt  <= WAIT_LOAD;
            end
          end
        end
        READ: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            rd_buf <= bus_data;
            if (we_q) begin
              state <= TURN;
            end else begin
              state     <= RESP;
              rsp_rdata <= load_ext;
              rsp_err   <= 1'b0;
            end
          end
        end
        TURN: begin
          state <= WRITE;
          wcnt  <= WAIT_LOAD;
        end
        WRITE: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            state     <= RESP;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode registered state only, so they never glitch on req_* changes.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign ram_cs    = (state == READ) || (state == TURN) || (state == WRITE);
  assign ram_oe    = (state == READ);
  assign ram_we    = (state == WRITE);
  assign bus_addr  = ram_cs ? {addr_q[63:3], 3'b000} : {64{1'bz}};
  assign bus_data  = (state == WRITE) ? wr_dword : {64{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: two instances (1 and 3 wait states) share
// a small RAM model; a vector table covers loads/stores, hand sequences the corners.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;

  logic        valid1, rdy1, rsp_valid1, err1, cs1, we1, oe1;
  logic        valid3, rdy3, rsp_valid3, err3, cs3, we3, oe3;
  logic [63:0] rdata1, addr1, rdata3, addr3;
  wire  [63:0] bus1;
  wire  [63:0] bus3;

  assign valid1 = req_valid & ~sel;
  assign valid3 = req_valid & sel;

  mem_bus_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rdata1), .rsp_err(err1),
    .bus_data(bus1), .bus_addr(addr1), .ram_cs(cs1), .ram_we(we1), .ram_oe(oe1)
  );

  mem_bus_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(valid3), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rdata3), .rsp_err(err3),
    .bus_data(bus3), .bus_addr(addr3), .ram_cs(cs3), .ram_we(we3), .ram_oe(oe3)
  );

  // RAM model: 8 dwords, read combinationally under cs&oe, written on edges under cs&we.
  logic [63:0] mem [0:7];
  assign bus1 = (cs1 && oe1) ? mem[addr1[5:3]] : {64{1'bz}};
  assign bus3 = (cs3 && oe3) ? mem[addr3[5:3]] : {64{1'bz}};
  always @(posedge clk) begin
    if (cs1 && we1) mem[addr1[5:3]] <= bus1;
    if (cs3 && we3) mem[addr3[5:3]] <= bus3;
  end

  logic        v_ready, v_rsp, v_err, v_cs, v_we, v_oe;
  logic [63:0] v_rdata, v_addr, v_bus;
  assign v_ready = sel ? rdy3 : rdy1;
  assign v_rsp   = sel ? rsp_valid3 : rsp_valid1;
  assign v_err   = sel ? err3 : err1;
  assign v_cs    = sel ? cs3 : cs1;
  assign v_we    = sel ? we3 : we1;
  assign v_oe    = sel ? oe3 : oe1;
  assign v_rdata = sel ? rdata3 : rdata1;
  assign v_addr  = sel ? addr3 : addr1;
  assign v_bus   = sel ? bus3 : bus1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic released(input logic [63:0] v);
    return (v === {64{1'bz}}) || (v === 64'h0);
  endfunction

  // Per-cycle snapshot after the accept edge; index k is cycle N+k.
  logic        cs_log  [64];
  logic        oe_log  [64];
  logic        we_log  [64];
  logic        rdy_log [64];
  logic        rel_log [64];
  logic [63:0] bus_log [64];
  int          cs_n, oe_n;

  task automatic wait_ready();
    int n;
    n = 0;
    while (!v_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!v_ready) check_int("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata);
    wait_ready();
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata,
                         output int lat, output logic [63:0] rdata, output logic err);
    lat   = -1;
    rdata = '0;
    err   = 1'b0;
    cs_n  = 0;
    oe_n  = 0;
    for (int k = 0; k < 64; k++) begin
      cs_log[k] = 0; oe_log[k] = 0; we_log[k] = 0;
      rdy_log[k] = 0; rel_log[k] = 0; bus_log[k] = '0;
    end
    issue(we, addr, size, uns, wdata);
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      cs_log[k]  = v_cs;
      oe_log[k]  = v_oe;
      we_log[k]  = v_we;
      rdy_log[k] = v_ready;
      rel_log[k] = released(v_bus);
      bus_log[k] = v_bus;
      if (v_cs) cs_n++;
      if (v_oe) oe_n++;
      if (v_rsp) begin
        lat   = k;
        rdata = v_rdata;
        err   = v_err;
        break;
      end
    end
    if (lat < 0) check_int("rsp_timeout", 0, 1);
  endtask

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_oe;
  } vec_t;

  vec_t vecs [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [63:0] rdata;
    logic        err;
    logic        saw_rsp;

    // Store first so later loads read known RAM contents (W=1 instance).
    vecs[0]  = '{1'b1, 64'h10, 2'd3, 1'b0, 64'h8877665544332211, 64'h0, 1'b0, 2, 0};
    vecs[1]  = '{1'b1, 64'h18, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2, 0};
    vecs[2]  = '{1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 64'h8877665544332211, 1'b0, 2, 1};
    vecs[3]  = '{1'b0, 64'h10, 2'd3, 1'b1, 64'h0, 64'h8877665544332211, 1'b0, 2, 1};
    vecs[4]  = '{1'b0, 64'h17, 2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, 1};
    vecs[5]  = '{1'b0, 64'h17, 2'd0, 1'b1, 64'h0, 64'h0000000000000088, 1'b0, 2, 1};
    vecs[6]  = '{1'b0, 64'h12, 2'd1, 1'b0, 64'h0, 64'h0000000000004433, 1'b0, 2, 1};
    vecs[7]  = '{1'b0, 64'h14, 2'd2, 1'b0, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 2, 1};
    vecs[8]  = '{1'b0, 64'h14, 2'd2, 1'b1, 64'h0, 64'h0000000088776655, 1'b0, 2, 1};
    vecs[9]  = '{1'b0, 64'h10, 2'd0, 1'b0, 64'h0, 64'h0000000000000011, 1'b0, 2, 1};
    vecs[10] = '{1'b0, 64'h1E, 2'd1, 1'b0, 64'h0, 64'h0000000000000123, 1'b0, 2, 1};
    vecs[11] = '{1'b0, 64'h12, 2'd2, 1'b0, 64'h0, 64'h0, 1'b1, 1, 0};
    vecs[12] = '{1'b0, 64'h11, 2'd1, 1'b0, 64'h0, 64'h0, 1'b1, 1, 0};
    vecs[13] = '{1'b0, 64'h14, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1, 1, 0};
    vecs[14] = '{1'b1, 64'h1E, 2'd1, 1'b0, 64'hFFFFBEEF, 64'h0, 1'b0, 4, 1};
    vecs[15] = '{1'b0, 64'h18, 2'd3, 1'b0, 64'h0, 64'hBEEF456789ABCDEF, 1'b0, 2, 1};
    vecs[16] = '{1'b0, 64'h1E, 2'd1, 1'b1, 64'h0, 64'h000000000000BEEF, 1'b0, 2, 1};
    vecs[17] = '{1'b0, 64'h1E, 2'd1, 1'b0, 64'h0, 64'hFFFFFFFFFFFFBEEF, 1'b0, 2, 1};

    // Clock/reset
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted mid-idle, mid-cycle
    #2 reset = 1'b1;
    #1;
    check64("rst_cs", v_cs, 1'b0);
    check64("rst_we", v_we, 1'b0);
    check64("rst_oe", v_oe, 1'b0);
    check64("rst_bus_rel", released(v_bus), 1'b1);
    check64("rst_addr_rel", released(v_addr), 1'b1);
    check64("rst_ready", v_ready, 1'b1);
    check64("rst_rsp_valid", v_rsp, 1'b0);
    check64("rst_rdata", v_rdata, 64'h0);
    check64("rst_err", v_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check64("post_rst_ready", v_ready, 1'b1);

    // Table-driven vectors on the 1-wait-state instance
    for (int i = 0; i < 18; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
              lat, rdata, err);
      check64($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check64($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check_int($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check_int($sformatf("v%0d_cs_cycles", i), cs_n, vecs[i].exp_lat - 1);
      check_int($sformatf("v%0d_oe_cycles", i), oe_n, vecs[i].exp_oe);
    end

    // Dword load strobe detail: oe only in N+1, aligned address on the bus
    run_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, lat, rdata, err);
    check64("ld_oe_n1", oe_log[1], 1'b1);
    check64("ld_oe_n2", oe_log[2], 1'b0);
    check_int("ld_lat", lat, 2);

    // RMW byte store, cycle by cycle
    run_req(1'b1, 64'h13, 2'd0, 1'b0, 64'hAB, lat, rdata, err);
    check64("rmw_n1_cs", cs_log[1], 1'b1);
    check64("rmw_n1_oe", oe_log[1], 1'b1);
    check64("rmw_n1_we", we_log[1], 1'b0);
    check64("rmw_turn_cs", cs_log[2], 1'b1);
    check64("rmw_turn_oe", oe_log[2], 1'b0);
    check64("rmw_turn_we", we_log[2], 1'b0);
    check64("rmw_turn_bus_rel", rel_log[2], 1'b1);
    check64("rmw_wr_we", we_log[3], 1'b1);
    check64("rmw_wr_oe", oe_log[3], 1'b0);
    check64("rmw_wr_data", bus_log[3], 64'h88776655AB332211);
    check_int("rmw_lat", lat, 4);
    check64("rmw_busy_ready", {rdy_log[1], rdy_log[2], rdy_log[3], rdy_log[4]}, 4'b0000);
    run_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, lat, rdata, err);
    check64("rmw_readback", rdata, 64'h88776655AB332211);

    // Three wait states
    sel = 1'b1;
    @(negedge clk);
    run_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, lat, rdata, err);
    check64("w3_ld_rdata", rdata, 64'h88776655AB332211);
    check_int("w3_ld_lat", lat, 4);
    check_int("w3_ld_oe_cycles", oe_n, 3);

    // Reset during the WRITE phase of an RMW (W=3: WRITE spans N+5..N+7)
    issue(1'b1, 64'h20, 2'd1, 1'b0, 64'h1234);
    repeat (5) @(negedge clk);
    check64("abort_in_write", v_we, 1'b1);
    reset = 1'b1;
    #1;
    check64("abort_cs", v_cs, 1'b0);
    check64("abort_we", v_we, 1'b0);
    check64("abort_oe", v_oe, 1'b0);
    check64("abort_bus_rel", released(v_bus), 1'b1);
    check64("abort_addr_rel", released(v_addr), 1'b1);
    saw_rsp = v_rsp;
    repeat (2) begin
      @(negedge clk);
      saw_rsp = saw_rsp | v_rsp;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_rsp = saw_rsp | v_rsp;
    end
    check64("abort_no_rsp", saw_rsp, 1'b0);
    check64("abort_ready", v_ready, 1'b1);
    run_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, lat, rdata, err);
    check64("after_abort_rdata", rdata, 64'h88776655AB332211);
    check_int("after_abort_lat", lat, 4);
    check64("after_abort_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
